// File: rtl/best_match_sched.sv
// best_match_sched: walks a candidate library of N entries and drives an
// external dist_calc unit through its ready/finished handshake. It tracks the
// candidate with the smallest squared distance. Ties keep the lower index.
//
// Optional feature, enabled by defining BEST_MATCH_THRESH_EN: a threshold
// (thresh_dist2) is latched at start. The search stops early, with hit=1, on
// the first candidate whose distance is at or below that threshold. When the
// macro is undefined, every search scans all N candidates.
module best_match_sched #(
  parameter int INDEX_BITS  = 8,
  parameter int NUMBER_BITS = 16
) (
  input  logic                          clk,
  input  logic                          reset,
`ifdef BEST_MATCH_THRESH_EN
  input  logic [2*(NUMBER_BITS+3):0]    thresh_dist2,
  output logic                          hit,
`endif
  input  logic                          start,
  input  logic [INDEX_BITS-1:0]         count,
  output logic [INDEX_BITS-1:0]         cand_addr,
  output logic                          calc_ready,
  input  logic                          calc_finished,
  input  logic [2*(NUMBER_BITS+3):0]    calc_dist2,
  output logic                          busy,
  output logic                          done,
  output logic                          found,
  output logic [INDEX_BITS-1:0]         best_index,
  output logic [2*(NUMBER_BITS+3):0]    best_dist2
);

  localparam int DIST_BITS = 2 * (NUMBER_BITS + 3) + 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_LOW,
    WAIT_HIGH,
    NEXT,
    DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;

  // cur is the candidate being scored. It also drives cand_addr, so the
  // address stays put from FETCH through WAIT_HIGH while dist_calc reads the
  // library output combinationally.
  logic [INDEX_BITS-1:0] cur;
  logic [INDEX_BITS-1:0] num_cand;
  logic [INDEX_BITS-1:0] last_idx;
  logic                  is_better;
  logic                  thresh_hit;

  // num_cand is never zero outside IDLE/DONE, so last_idx cannot underflow
  // where it is used.
  assign last_idx  = num_cand - INDEX_BITS'(1);
  assign is_better = (calc_dist2 < best_dist2);

`ifdef BEST_MATCH_THRESH_EN
  logic [DIST_BITS-1:0] thresh_q;
  assign thresh_hit = (calc_dist2 <= thresh_q);
`else
  assign thresh_hit = 1'b0;
`endif

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign cand_addr = cur;

  // State register; reset aborts any search, including one mid-calculation.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with non-blocking assignments so every
    // flop samples pre-edge values, independent of statement order.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    // NOTE: defaults come first so every path assigns every output and no
    // latch is inferred.
    state_nxt  = state;
    calc_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (count == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        state_nxt = ISSUE;
      end
      ISSUE: begin
        // Wait for dist_calc to be idle. This covers the case where a reset
        // cut short a previous calculation that is still running.
        if (calc_finished) begin
          calc_ready = 1'b1;
          state_nxt  = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!calc_finished) begin
          state_nxt = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (calc_finished) begin
          state_nxt = thresh_hit ? DONE : NEXT;
        end
      end
      NEXT: begin
        state_nxt = (cur == last_idx) ? DONE : FETCH;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Search datapath: candidate counter, running minimum and result flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur        <= '0;
      num_cand   <= '0;
      found      <= 1'b0;
      best_index <= '0;
      best_dist2 <= '1;
`ifdef BEST_MATCH_THRESH_EN
      hit        <= 1'b0;
      thresh_q   <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            num_cand   <= count;
            cur        <= '0;
            found      <= 1'b0;
            best_index <= '0;
            best_dist2 <= '1;
`ifdef BEST_MATCH_THRESH_EN
            hit        <= 1'b0;
            thresh_q   <= thresh_dist2;
`endif
          end
        end
        WAIT_HIGH: begin
          if (calc_finished) begin
            found <= 1'b1;
            // The comparison is strict, so an equal distance never displaces
            // an earlier index.
            if (is_better) begin
              best_dist2 <= calc_dist2;
              best_index <= cur;
            end
`ifdef BEST_MATCH_THRESH_EN
            if (thresh_hit) begin
              hit <= 1'b1;
            end
`endif
          end
        end
        NEXT: begin
          // cur stops at N-1 and never wraps.
          if (cur != last_idx) begin
            cur <= cur + INDEX_BITS'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_best_match_sched.sv
// Bench for best_match_sched. It pairs the DUT with a 1-cycle-latency
// candidate ROM and a behavioural dist_calc, which reads the ROM output while
// it computes. A search model works out the expected results from the
// distance table. The compare process checks the DUT against the model
// whenever the results are valid, and also checks the handshake rules.
module tb_best_match_sched;

  localparam int IB = 8;
  localparam int NB = 16;
  localparam int DW = 2 * (NB + 3) + 1;
  typedef logic [DW-1:0] dist_t;
  localparam dist_t ONES = '1;

  logic          clk;
  logic          reset;
  logic          start;
  logic [IB-1:0] count;
  logic [IB-1:0] cand_addr;
  logic          calc_ready;
  logic          calc_finished;
  dist_t         calc_dist2;
  logic          busy;
  logic          done;
  logic          found;
  logic [IB-1:0] best_index;
  dist_t         best_dist2;
  dist_t         thresh;
  bit            thresh_en;
`ifdef BEST_MATCH_THRESH_EN
  logic          hit;
`endif

  best_match_sched #(.INDEX_BITS(IB), .NUMBER_BITS(NB)) dut (
    .clk           (clk),
    .reset         (reset),
`ifdef BEST_MATCH_THRESH_EN
    .thresh_dist2  (thresh),
    .hit           (hit),
`endif
    .start         (start),
    .count         (count),
    .cand_addr     (cand_addr),
    .calc_ready    (calc_ready),
    .calc_finished (calc_finished),
    .calc_dist2    (calc_dist2),
    .busy          (busy),
    .done          (done),
    .found         (found),
    .best_index    (best_index),
    .best_dist2    (best_dist2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Candidate library: the entry's distance appears one cycle after the address.
  dist_t rom [0:255];
  dist_t rom_q;
  always @(posedge clk) rom_q <= rom[cand_addr];

  // dist_calc: finished drops after ready and stays low for 4 cycles. The
  // result is taken from the ROM output at the end of that window.
  int calc_cnt = 0;
  initial calc_dist2 = '0;
  assign calc_finished = (calc_cnt == 0);
  always @(posedge clk) begin
    if (calc_cnt == 0) begin
      if (calc_ready) calc_cnt <= 4;
    end else begin
      calc_cnt <= calc_cnt - 1;
      if (calc_cnt == 1) calc_dist2 <= rom_q;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected results of the last completed search, and of the one in flight.
  dist_t         exp_dist,  pend_dist;
  logic [IB-1:0] exp_idx,   pend_idx;
  logic          exp_found, pend_found;
  logic          exp_hit,   pend_hit;
  int            pend_pulses;
  int            pulses;

  // Search model: scan candidates in order, keep the first minimum, and stop
  // at the first entry within the threshold when early exit is enabled.
  function automatic void model_search(input int n);
    pend_dist   = ONES;
    pend_idx    = '0;
    pend_found  = 1'b0;
    pend_hit    = 1'b0;
    pend_pulses = 0;
    for (int i = 0; i < n; i++) begin
      pend_pulses++;
      pend_found = 1'b1;
      if (rom[i] < pend_dist) begin
        pend_dist = rom[i];
        pend_idx  = IB'(i);
      end
      if (thresh_en && rom[i] <= thresh) begin
        pend_hit = 1'b1;
        break;
      end
    end
  endfunction

  // Compare process: handshake rules every cycle, results whenever valid.
  logic          prev_ready = 1'b0;
  bit            stab_en    = 1'b0;
  logic [IB-1:0] stab_addr  = '0;
  always @(negedge clk) begin
    if (reset) begin
      exp_dist   = ONES;
      exp_idx    = '0;
      exp_found  = 1'b0;
      exp_hit    = 1'b0;
      stab_en    = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (calc_ready) begin
        pulses++;
        check("ready_not_back_to_back", prev_ready, 0);
        check("ready_only_when_finished", calc_finished, 1);
        stab_en   = 1'b1;
        stab_addr = cand_addr;
      end else if (stab_en && calc_cnt != 0) begin
        check("cand_addr_stable", cand_addr, stab_addr);
      end else if (calc_cnt == 0) begin
        stab_en = 1'b0;
      end
      if (done) begin
        exp_dist  = pend_dist;
        exp_idx   = pend_idx;
        exp_found = pend_found;
        exp_hit   = pend_hit;
      end
      if (!busy || done) begin
        check("found", found, exp_found);
        check("best_index", best_index, exp_idx);
        check("best_dist2", best_dist2, exp_dist);
`ifdef BEST_MATCH_THRESH_EN
        check("hit", hit, exp_hit);
`endif
      end
      prev_ready = calc_ready;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a search and wait (bounded) for done. An optional start pulse is
  // injected while busy. cyc is the number of edges from the start edge to done.
  task automatic run_search(input int n, input int max_cyc, input int inject, output int cyc);
    model_search(n);
    pulses = 0;
    count  = IB'(n);
    start  = 1'b1;
    step();
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < max_cyc) begin
      if (cyc == inject) begin
        start = 1'b1;
        count = IB'(7);
      end
      step();
      start = 1'b0;
      cyc++;
    end
    check("done_reached", done, 1);
    step();
    check("idle_after_done", busy, 0);
    check("pulse_count", pulses, pend_pulses);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int cyc;
  int k;

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    count     = '0;
    thresh    = '0;
    thresh_en = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    step();
    step();
    reset = 1'b0;

    // Reset values
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_calc_ready", calc_ready, 0);
    check("rst_found", found, 0);
    check("rst_cand_addr", cand_addr, 0);
    check("rst_best_index", best_index, 0);
    check("rst_best_dist2", best_dist2, ONES);

    // N=1
    rom[0] = dist_t'(77);
    run_search(1, 20, -1, cyc);
    check("n1_latency_le_12", cyc <= 12, 1);
    check("n1_found", found, 1);
    check("n1_best_index", best_index, 0);
    check("n1_pulses", pulses, 1);

    // N=4, distances 50,20,20,70 with a tie
    rom[0] = dist_t'(50); rom[1] = dist_t'(20); rom[2] = dist_t'(20); rom[3] = dist_t'(70);
    run_search(4, 60, -1, cyc);
    check("n4_latency_le_40", cyc <= 40, 1);
    check("n4_best_index", best_index, 1);
    check("n4_best_dist2", best_dist2, 20);

    // N=0
    run_search(0, 10, -1, cyc);
    check("n0_done_next_cycle", cyc, 1);
    check("n0_found", found, 0);
    check("n0_best_dist2", best_dist2, ONES);
    check("n0_no_ready", pulses, 0);

    // start pulsed during WAIT_HIGH is ignored
    rom[0] = dist_t'(9); rom[1] = dist_t'(3); rom[2] = dist_t'(5);
    run_search(3, 60, 4, cyc);
    check("ign_pulses", pulses, 3);
    check("ign_best_index", best_index, 1);

    // Minimum at the last index
    rom[0] = dist_t'(30); rom[1] = dist_t'(20); rom[2] = dist_t'(10);
    run_search(3, 60, -1, cyc);
    check("desc_best_index", best_index, 2);

    // All ties keep index 0
    for (int i = 0; i < 5; i++) rom[i] = dist_t'(8);
    run_search(5, 80, -1, cyc);
    check("tie_best_index", best_index, 0);

    // Candidate at the maximum distance still counts as scored
    rom[0] = ONES;
    run_search(1, 20, -1, cyc);
    check("max_found", found, 1);
    check("max_best_dist2", best_dist2, ONES);

    // Reset in WAIT_LOW, then N=2
    rom[0] = dist_t'(40); rom[1] = dist_t'(15);
    count = IB'(2);
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!calc_ready && k < 10) begin
      step();
      k++;
    end
    check("rst_mid_saw_issue", calc_ready, 1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstm_busy", busy, 0);
    check("rstm_done", done, 0);
    check("rstm_calc_ready", calc_ready, 0);
    check("rstm_found", found, 0);
    check("rstm_cand_addr", cand_addr, 0);
    check("rstm_best_index", best_index, 0);
    check("rstm_best_dist2", best_dist2, ONES);
    run_search(2, 60, -1, cyc);
    check("rstm_new_best_index", best_index, 1);
    check("rstm_new_best_dist2", best_dist2, 15);

`ifdef BEST_MATCH_THRESH_EN
    // Early exit: thresh=30, distances 50,25,10
    thresh_en = 1'b1;
    thresh    = dist_t'(30);
    rom[0] = dist_t'(50); rom[1] = dist_t'(25); rom[2] = dist_t'(10);
    run_search(3, 60, -1, cyc);
    check("th_hit", hit, 1);
    check("th_best_index", best_index, 1);
    check("th_pulses", pulses, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
